// File: rtl/dpram_bist_pkg.sv
// Shared types and default constants for the dual-port RAM BIST controller.
package dpram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_RD_LAT = 2;
  localparam int unsigned DEF_SEED_A = 5;
  localparam int unsigned DEF_SEED_B = 10;

  localparam int unsigned FAIL_W   = 8;
  localparam int unsigned FAIL_MAX = 255;

  // Saturating add of 0..2 mismatches onto the failure counter.
  function automatic logic [FAIL_W-1:0] fail_add(input logic [FAIL_W-1:0] cnt,
                                                  input logic [1:0]        inc);
    logic [FAIL_W:0] sum;
    sum = (FAIL_W+1)'(cnt) + (FAIL_W+1)'(inc);
    return (sum > (FAIL_W+1)'(FAIL_MAX)) ? FAIL_W'(FAIL_MAX) : sum[FAIL_W-1:0];
  endfunction

endpackage

// File: rtl/dpram_bist_rd_pipe.sv
// Delay line carrying read-valid, expected data and port-A address from issue
// to the cycle the RAM returns data.
module dpram_bist_rd_pipe
  import dpram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp_a,
  input  logic [DATA_W-1:0] in_exp_b,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_exp_a,
  output logic [DATA_W-1:0] out_exp_b,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] exp_a [DEPTH];
  logic [DATA_W-1:0] exp_b [DEPTH];
  logic [ADDR_W-1:0] addr  [DEPTH];

  // Reset empties the line so in-flight compares are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        exp_a[k] <= '0;
        exp_b[k] <= '0;
        addr[k]  <= '0;
      end
    end else begin
      vld[0]   <= in_valid;
      exp_a[0] <= in_exp_a;
      exp_b[0] <= in_exp_b;
      addr[0]  <= in_addr;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k]   <= vld[k-1];
        exp_a[k] <= exp_a[k-1];
        exp_b[k] <= exp_b[k-1];
        addr[k]  <= addr[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_exp_a = exp_a[DEPTH-1];
  assign out_exp_b = exp_b[DEPTH-1];
  assign out_addr  = addr[DEPTH-1];

endmodule

// File: rtl/dpram_bist.sv
// March-style BIST for a dual-port RAM: write a seeded pattern over both ports,
// read it back pipelined and count mismatches. Define DPRAM_BIST_INV_PASS_EN to
// add a second pass with bitwise-inverted data.
module dpram_bist
  import dpram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned SEED_A = DEF_SEED_A,
  parameter int unsigned SEED_B = DEF_SEED_B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [ADDR_W-1:0] addr_A,
  output logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] data_in_A,
  output logic [DATA_W-1:0] data_in_B,
  output logic              mode_A,
  output logic              mode_B,
  input  logic [DATA_W-1:0] data_out_A,
  input  logic [DATA_W-1:0] data_out_B
);

  localparam int unsigned IDX_W      = ADDR_W - 1;
  localparam int unsigned IDX_LAST   = (1 << IDX_W) - 1;
  localparam int unsigned DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned DRAIN_LAST = RD_LAT - 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               inv, inv_nxt;
  logic               start_ok;

  logic               wr_nxt, rd_nxt;
  logic [DATA_W-1:0]  pat_a, pat_b;

  logic               iss_valid;
  logic [DATA_W-1:0]  iss_exp_a, iss_exp_b;
  logic [ADDR_W-1:0]  iss_addr;

  logic               chk_valid;
  logic [DATA_W-1:0]  chk_exp_a, chk_exp_b;
  logic [ADDR_W-1:0]  chk_addr;
  logic               mis_a, mis_b;
  logic [FAIL_W-1:0]  fail_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      inv       <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      drain_cnt <= drain_nxt;
      inv       <= inv_nxt;
    end
  end

  // Next state: one address pair per cycle, drain retires reads still in flight.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    drain_nxt = drain_cnt;
    inv_nxt   = inv;
    start_ok  = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = ST_WRITE;
          idx_nxt   = '0;
          inv_nxt   = 1'b0;
        end
      end
      ST_WRITE: begin
        if (idx == IDX_W'(IDX_LAST)) begin
          state_nxt = ST_READ;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_READ: begin
        if (idx == IDX_W'(IDX_LAST)) begin
          state_nxt = ST_DRAIN;
          idx_nxt   = '0;
          drain_nxt = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
`ifdef DPRAM_BIST_INV_PASS_EN
          if (!inv) begin
            state_nxt = ST_WRITE;
            inv_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          drain_nxt = drain_cnt + DRAIN_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pattern for the pair that will be on the bus next cycle.
  always_comb begin
    wr_nxt = (state_nxt == ST_WRITE);
    rd_nxt = (state_nxt == ST_READ);
    pat_a  = DATA_W'(SEED_A + 32'(idx_nxt));
    pat_b  = DATA_W'(SEED_B + 32'(idx_nxt));
    if (inv_nxt) begin
      pat_a = ~pat_a;
      pat_b = ~pat_b;
    end
  end

  // RAM-side outputs and read-issue record, registered from next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      mode_A    <= 1'b0;
      mode_B    <= 1'b0;
      addr_A    <= '0;
      addr_B    <= '0;
      data_in_A <= '0;
      data_in_B <= '0;
      iss_valid <= 1'b0;
      iss_exp_a <= '0;
      iss_exp_b <= '0;
      iss_addr  <= '0;
    end else begin
      busy      <= wr_nxt || rd_nxt || (state_nxt == ST_DRAIN);
      mode_A    <= wr_nxt;
      mode_B    <= wr_nxt;
      addr_A    <= (wr_nxt || rd_nxt) ? {idx_nxt, 1'b0} : '0;
      addr_B    <= (wr_nxt || rd_nxt) ? {idx_nxt, 1'b1} : '0;
      data_in_A <= wr_nxt ? pat_a : '0;
      data_in_B <= wr_nxt ? pat_b : '0;
      iss_valid <= rd_nxt;
      iss_exp_a <= rd_nxt ? pat_a : '0;
      iss_exp_b <= rd_nxt ? pat_b : '0;
      iss_addr  <= rd_nxt ? {idx_nxt, 1'b0} : '0;
    end
  end

  dpram_bist_rd_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iss_valid),
    .in_exp_a  (iss_exp_a),
    .in_exp_b  (iss_exp_b),
    .in_addr   (iss_addr),
    .out_valid (chk_valid),
    .out_exp_a (chk_exp_a),
    .out_exp_b (chk_exp_b),
    .out_addr  (chk_addr)
  );

  always_comb begin
    mis_a    = chk_valid && (data_out_A != chk_exp_a);
    mis_b    = chk_valid && (data_out_B != chk_exp_b);
    fail_nxt = fail_add(fail_count, 2'(mis_a) + 2'(mis_b));
  end

  // Result registers; a zero count doubles as the "no failure seen yet" flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (start_ok) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      fail_count <= fail_nxt;
      if ((mis_a || mis_b) && (fail_count == '0))
        first_fail_addr <= mis_a ? chk_addr : (chk_addr | ADDR_W'(1));
      if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
        done <= 1'b1;
        pass <= (fail_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_dpram_bist.sv
// Directed bench for dpram_bist against a behavioural dual-port RAM with
// selectable read latency and single-bit faults.
module tb_dpram_bist;

`ifdef DPRAM_BIST_INV_PASS_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass;
  logic [7:0] fail_count;
  logic [5:0] first_fail_addr;
  logic [5:0] addr_A, addr_B;
  logic [7:0] data_in_A, data_in_B;
  logic       mode_A, mode_B;
  logic [7:0] data_out_A, data_out_B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_bist dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr),
    .addr_A          (addr_A),
    .addr_B          (addr_B),
    .data_in_A       (data_in_A),
    .data_in_B       (data_in_B),
    .mode_A          (mode_A),
    .mode_B          (mode_B),
    .data_out_A      (data_out_A),
    .data_out_B      (data_out_B)
  );

  // RAM model: kind 0 none, 1 bit0 stuck-at-0, 2 bit0 stuck-at-1, 3 bit0 flipped.
  int cur_kind = 0;
  int cur_fa0  = -1;
  int cur_fa1  = -1;
  int cur_lat  = 2;

  logic [7:0] mem [64];
  logic [7:0] r1a, r1b, r2a, r2b;

  function automatic logic [7:0] flt(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (int'(a) == cur_fa0 || int'(a) == cur_fa1) begin
      case (cur_kind)
        1: r = d & 8'hFE;
        2: r = d | 8'h01;
        3: r = d ^ 8'h01;
        default: r = d;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (mode_A) mem[addr_A] <= data_in_A;
    if (mode_B) mem[addr_B] <= data_in_B;
    r1a <= flt(addr_A, mem[addr_A]);
    r1b <= flt(addr_B, mem[addr_B]);
    r2a <= r1a;
    r2b <= r1b;
  end

  assign data_out_A = (cur_lat == 1) ? r1a : r2a;
  assign data_out_B = (cur_lat == 1) ? r1b : r2b;

  // Write monitor: every write must carry the seeded pattern (or its inverse).
  int         wr_cnt = 0;
  int         wr_bad = 0;
  logic [7:0] last_wr0   = 8'h00;
  logic [7:0] last_wr62  = 8'h00;
  logic [7:0] last_wr63  = 8'h00;

  function automatic bit wr_ok(input logic [5:0] aa, input logic [5:0] ab,
                               input logic [7:0] da, input logic [7:0] db,
                               input logic ma, input logic mb);
    logic [7:0] pa, pb;
    pa = 8'(5 + int'(aa) / 2);
    pb = 8'(10 + int'(aa) / 2);
    return (ma == mb) && (aa[0] == 1'b0) && (ab == (aa | 6'd1)) &&
           ((da == pa && db == pb) || (da == ~pa && db == ~pb));
  endfunction

  always @(posedge clk) begin
    if (mode_A || mode_B) begin
      wr_cnt <= wr_cnt + 1;
      if (!wr_ok(addr_A, addr_B, data_in_A, data_in_B, mode_A, mode_B))
        wr_bad <= wr_bad + 1;
      if (addr_A == 6'd0)  last_wr0  <= data_in_A;
      if (addr_A == 6'd62) last_wr62 <= data_in_A;
      if (addr_B == 6'd63) last_wr63 <= data_in_B;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int kind;
    int fa0;
    int fa1;
    int lat;
    int fail_s;
    int first_s;
    int fail_i;
    int first_i;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int v);
    int cyc;
    int base_wr, base_bad;
    int e_fail, e_first;
    string tag;
    tag      = $sformatf("v%0d", v);
    cur_kind = vecs[v].kind;
    cur_fa0  = vecs[v].fa0;
    cur_fa1  = vecs[v].fa1;
    cur_lat  = vecs[v].lat;
    e_fail   = INV ? vecs[v].fail_i  : vecs[v].fail_s;
    e_first  = INV ? vecs[v].first_i : vecs[v].first_s;
    base_wr  = wr_cnt;
    base_bad = wr_bad;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_restart"}, {done, busy, pass, fail_count, first_fail_addr},
          {1'b0, 1'b1, 1'b0, 8'd0, 6'd0});
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_done_cycle"}, cyc, INV ? 133 : 67);
    check({tag, "_fail_count"}, fail_count, e_fail);
    check({tag, "_first_fail"}, first_fail_addr, e_first);
    check({tag, "_pass"}, {pass, busy}, {(e_fail == 0), 1'b0});
    check({tag, "_ram_idle"}, {mode_A, mode_B, addr_A, addr_B, data_in_A, data_in_B}, 0);
    check({tag, "_wr_count"}, wr_cnt - base_wr, INV ? 64 : 32);
    check({tag, "_wr_pattern"}, wr_bad - base_bad, 0);
    repeat (3) @(posedge clk);
    #1 check({tag, "_hold"}, {done, pass, fail_count}, {1'b1, (e_fail == 0), 8'(e_fail)});
  endtask

  initial begin
    //         kind fa0 fa1 lat fail_s first_s fail_i first_i
    vecs[0] = '{0, -1, -1, 2,   0, 0,   0, 0};
    // Address 7 holds 13 (odd): only stuck-at-0 is visible in the true pass.
    vecs[1] = '{1,  7, -1, 2,   1, 7,   1, 7};
    vecs[2] = '{2,  7, -1, 2,   0, 0,   1, 7};
    vecs[3] = '{3,  4,  5, 2,   2, 4,   4, 4};
    vecs[4] = '{0, -1, -1, 1,  64, 0, 128, 0};
    vecs[5] = '{0, -1, -1, 2,   0, 0,   0, 0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {busy, done, pass, mode_A, mode_B}, 0);
    check("reset_counts", {fail_count, first_fail_addr}, 0);
    check("reset_bus", {addr_A, addr_B, data_in_A, data_in_B}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_hold", {busy, done, mode_A}, 0);

    for (int v = 0; v < 6; v++) run_vec(v);
    check("last_wr_addr0", last_wr0, INV ? 8'hFA : 8'h05);
    check("last_wr_addr62", last_wr62, INV ? 8'hDB : 8'd36);
    check("last_wr_addr63", last_wr63, INV ? 8'hD6 : 8'd41);

    // start during WRITE is ignored; reset mid-test returns to IDLE.
    cur_kind = 0;
    cur_lat  = 2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_start_ignored", {busy, mode_A, addr_A, data_in_A}, {1'b1, 1'b1, 6'd20, 8'd15});
    repeat (9) @(posedge clk);
    #1 check("pre_reset_bus", {mode_B, addr_A, addr_B, data_in_B}, {1'b1, 6'd38, 6'd39, 8'd29});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_flags", {busy, done, pass, mode_A, mode_B}, 0);
    check("midreset_bus", {addr_A, addr_B, data_in_A, data_in_B, fail_count, first_fail_addr}, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_reset_idle", {busy, done, mode_A, addr_A}, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
